// File: rtl/ql_episode_sequencer.sv
// Episode/step sequencer for the Q-learning datapath: one registered step request per step, epsilon-greedy action hint from a 16-bit LFSR.
// Registered outputs; any step latency >=1 cycle is accepted with no timeout, and i_abort returns to IDLE on the next edge.
module ql_episode_sequencer #(
    parameter int STATES_WIDTH        = 4,
    parameter int ACTIONS_WIDTH       = 2,
    parameter int COUNTER_WIDTH       = 16,
    parameter int MAX_EPISODES        = 3,
    parameter int MAX_STEPS           = 4,
    parameter int GOAL_STATE          = 15,
    parameter int EPS_THRESH          = 26,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [STATES_WIDTH-1:0]  i_first_st,
    input  logic                     i_step_done,
    input  logic [STATES_WIDTH-1:0]  i_next_st,
    output logic                     o_step_req,
    output logic [STATES_WIDTH-1:0]  o_cur_st,
    output logic [ACTIONS_WIDTH-1:0] o_at_random,
    output logic                     o_explore,
    output logic [COUNTER_WIDTH-1:0] o_count,
    output logic [COUNTER_WIDTH-1:0] o_step,
    output logic [COUNTER_WIDTH-1:0] o_goal_hits,
    output logic                     o_busy,
    output logic                     o_write_file_en,
    output logic                     o_valid
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EP_END, S_DONE} state_t;

    localparam logic [COUNTER_WIDTH-1:0] LAST_EP   = COUNTER_WIDTH'(MAX_EPISODES - 1);
    localparam logic [COUNTER_WIDTH-1:0] LAST_STEP = COUNTER_WIDTH'(MAX_STEPS - 1);
    localparam logic [COUNTER_WIDTH-1:0] ONE       = COUNTER_WIDTH'(1);
    localparam logic [STATES_WIDTH-1:0]  GOAL      = STATES_WIDTH'(GOAL_STATE);
    localparam logic [8:0]               EPS       = 9'(EPS_THRESH);

    state_t                     state, state_nxt;
    logic [15:0]                lfsr, lfsr_nxt;
    logic [STATES_WIDTH-1:0]    cur_st_nxt;
    logic [COUNTER_WIDTH-1:0]   count_nxt, step_nxt, goal_nxt;
    logic [ACTIONS_WIDTH-1:0]   rnd_nxt;
    logic                       explore_nxt;

    // Galois form of x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
    endfunction

    always_comb begin
        state_nxt  = state;
        lfsr_nxt   = lfsr;
        cur_st_nxt = o_cur_st;
        count_nxt  = o_count;
        step_nxt   = o_step;
        goal_nxt   = o_goal_hits;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt  = S_REQ;
                    count_nxt  = '0;
                    step_nxt   = '0;
                    goal_nxt   = '0;
                    cur_st_nxt = i_first_st;
                    lfsr_nxt   = LFSR_SEED;
                end
            end
            S_REQ: begin
                if (i_abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                    lfsr_nxt  = lfsr_step(lfsr);
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    state_nxt = S_IDLE;
                end else if (i_step_done) begin
                    cur_st_nxt = i_next_st;
                    if (i_next_st == GOAL) begin
                        goal_nxt  = o_goal_hits + ONE;
                        state_nxt = S_EP_END;
                    end else if (o_step == LAST_STEP) begin
                        state_nxt = S_EP_END;
                    end else begin
                        step_nxt  = o_step + ONE;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_EP_END: begin
                if (i_abort) begin
                    state_nxt = S_IDLE;
                end else if (o_count == LAST_EP) begin
                    state_nxt = S_DONE;
                end else begin
                    count_nxt  = o_count + ONE;
                    step_nxt   = '0;
                    cur_st_nxt = i_first_st;
                    state_nxt  = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The action hint is captured on REQ entry so it is stable for the whole request cycle
    always_comb begin
        rnd_nxt     = o_at_random;
        explore_nxt = o_explore;
        if (state_nxt == S_REQ) begin
            rnd_nxt     = lfsr_nxt[15 -: ACTIONS_WIDTH];
            explore_nxt = ({1'b0, lfsr_nxt[7:0]} < EPS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            lfsr            <= LFSR_SEED;
            o_cur_st        <= '0;
            o_count         <= '0;
            o_step          <= '0;
            o_goal_hits     <= '0;
            o_at_random     <= '0;
            o_explore       <= 1'b0;
            o_step_req      <= 1'b0;
            o_busy          <= 1'b0;
            o_write_file_en <= 1'b0;
            o_valid         <= 1'b0;
        end else begin
            state           <= state_nxt;
            lfsr            <= lfsr_nxt;
            o_cur_st        <= cur_st_nxt;
            o_count         <= count_nxt;
            o_step          <= step_nxt;
            o_goal_hits     <= goal_nxt;
            o_at_random     <= rnd_nxt;
            o_explore       <= explore_nxt;
            o_step_req      <= (state_nxt == S_REQ);
            o_busy          <= (state_nxt != S_IDLE);
            o_write_file_en <= (state_nxt == S_EP_END);
            o_valid         <= (state_nxt == S_DONE);
        end
    end
endmodule

// File: tb/tb_ql_episode_sequencer.sv
// Scoreboard bench: a run-level model queues expected request/episode-end/done records; a monitor pops them on DUT pulses.
module tb_ql_episode_sequencer;
    localparam int          EPS_N = 3;
    localparam int          STEPS = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [3:0]  GOAL  = 4'd15;

    typedef struct { logic [3:0] st; int ep; int s; int goals; logic [1:0] rnd; logic expl; } req_t;
    typedef struct { logic [3:0] st; int ep; int s; int goals; } end_t;

    logic clk = 1'b0;
    logic rst_n, i_start, i_abort, i_step_done;
    logic [3:0] i_first_st, i_next_st;

    logic o_step_req, o_explore, o_busy, o_write_file_en, o_valid;
    logic [3:0] o_cur_st;
    logic [1:0] o_at_random;
    logic [15:0] o_count, o_step, o_goal_hits;

    logic a_step_req, a_explore, a_busy, a_wr, a_valid;
    logic [3:0] a_cur_st;
    logic [1:0] a_rnd;
    logic [15:0] a_count, a_step, a_goals;

    logic b_step_req, b_explore, b_busy, b_wr, b_valid;
    logic [3:0] b_cur_st;
    logic [1:0] b_rnd;
    logic [15:0] b_count, b_step, b_goals;

    int n_checks = 0, n_fail = 0;
    int n_req_seen, n_ep_seen, n_done_seen;
    bit mon_en;
    req_t req_q[$];
    end_t ep_q[$], done_q[$];
    req_t mr;
    end_t me;

    always #5 clk = ~clk;

    ql_episode_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_first_st(i_first_st),
        .i_step_done(i_step_done), .i_next_st(i_next_st), .o_step_req(o_step_req), .o_cur_st(o_cur_st),
        .o_at_random(o_at_random), .o_explore(o_explore), .o_count(o_count), .o_step(o_step),
        .o_goal_hits(o_goal_hits), .o_busy(o_busy), .o_write_file_en(o_write_file_en), .o_valid(o_valid));

    ql_episode_sequencer #(.EPS_THRESH(0)) dut_e0 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_first_st(i_first_st),
        .i_step_done(i_step_done), .i_next_st(i_next_st), .o_step_req(a_step_req), .o_cur_st(a_cur_st),
        .o_at_random(a_rnd), .o_explore(a_explore), .o_count(a_count), .o_step(a_step),
        .o_goal_hits(a_goals), .o_busy(a_busy), .o_write_file_en(a_wr), .o_valid(a_valid));

    ql_episode_sequencer #(.EPS_THRESH(256)) dut_e256 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_first_st(i_first_st),
        .i_step_done(i_step_done), .i_next_st(i_next_st), .o_step_req(b_step_req), .o_cur_st(b_cur_st),
        .o_at_random(b_rnd), .o_explore(b_explore), .o_count(b_count), .o_step(b_step),
        .o_goal_hits(b_goals), .o_busy(b_busy), .o_write_file_en(b_wr), .o_valid(b_valid));

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {o_step_req, o_cur_st, o_at_random, o_explore, o_count, o_step, o_goal_hits,
                     o_busy, o_write_file_en, o_valid}, 0);
    endtask

    task automatic check_idle_cycles(input string name, input int n);
        int busy_cycles = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            busy_cycles += int'(o_busy);
        end
        check(name, busy_cycles, 0);
    endtask

    function automatic logic [15:0] galois(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic void queue_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT pulse with no expected record queued", name);
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (o_step_req) begin
                n_req_seen++;
                if (req_q.size() == 0) queue_fail("unexpected_step_req");
                else begin
                    mr = req_q.pop_front();
                    check("req_cur_st", o_cur_st, mr.st);
                    check("req_count", o_count, mr.ep);
                    check("req_step", o_step, mr.s);
                    check("req_goal_hits", o_goal_hits, mr.goals);
                    check("req_at_random", o_at_random, mr.rnd);
                    check("req_explore", o_explore, mr.expl);
                    check("req_busy", o_busy, 1);
                end
            end
            if (o_write_file_en) begin
                n_ep_seen++;
                if (ep_q.size() == 0) queue_fail("unexpected_write_file_en");
                else begin
                    me = ep_q.pop_front();
                    check("ep_cur_st", o_cur_st, me.st);
                    check("ep_count", o_count, me.ep);
                    check("ep_step", o_step, me.s);
                    check("ep_goal_hits", o_goal_hits, me.goals);
                end
            end
            if (o_valid) begin
                n_done_seen++;
                if (done_q.size() == 0) queue_fail("unexpected_valid");
                else begin
                    me = done_q.pop_front();
                    check("done_cur_st", o_cur_st, me.st);
                    check("done_count", o_count, me.ep);
                    check("done_step", o_step, me.s);
                    check("done_goal_hits", o_goal_hits, me.goals);
                end
            end
            if (a_step_req) check("explore_thresh0", a_explore, 0);
            if (b_step_req) check("explore_thresh256", b_explore, 1);
        end
    end

    // goal_ep/goal_step force GOAL at one step; abort_req is the request index whose response carries i_abort
    task automatic do_run(input logic [3:0] first, input int goal_pct, input int goal_ep,
                          input int goal_step, input int abort_req);
        logic [15:0] l;
        logic [3:0] st, nx;
        int goals, k, last_s, exp_req, exp_ep, cnt;
        bit aborted, glitch;
        logic [3:0] nxq[$];
        req_t r, ab;
        end_t e;
        l = SEED; goals = 0; k = 0; last_s = 0; exp_req = 0; exp_ep = 0; aborted = 0; st = first;
        for (int ep = 0; ep < EPS_N && !aborted; ep++) begin
            st = first;
            for (int s = 0; s < STEPS; s++) begin
                r.st = st; r.ep = ep; r.s = s; r.goals = goals;
                r.rnd = l[15:14]; r.expl = (l[7:0] < 8'd26);
                req_q.push_back(r);
                exp_req++;
                l = galois(l);
                if (ep == goal_ep && s == goal_step) nx = GOAL;
                else if ($urandom_range(0, 99) < goal_pct) nx = GOAL;
                else nx = 4'($urandom_range(0, 14));
                nxq.push_back(nx);
                if (k == abort_req) begin aborted = 1; ab = r; break; end
                k++;
                st = nx;
                last_s = s;
                if (nx == GOAL || s == STEPS - 1) begin
                    if (nx == GOAL) goals++;
                    e.st = st; e.ep = ep; e.s = s; e.goals = goals;
                    ep_q.push_back(e);
                    exp_ep++;
                    break;
                end
            end
        end
        if (!aborted) begin
            e.st = st; e.ep = EPS_N - 1; e.s = last_s; e.goals = goals;
            done_q.push_back(e);
        end

        n_req_seen = 0; n_ep_seen = 0; n_done_seen = 0;
        i_first_st = first;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        for (int idx = 0; idx < nxq.size(); idx++) begin
            cnt = 0;
            while (!o_step_req && cnt < 64) begin @(negedge clk); cnt++; end
            check("step_req_wait", o_step_req, 1);
            if (!o_step_req) break;
            glitch = ($urandom_range(0, 3) == 0);
            if (glitch) begin i_step_done = 1'b1; i_next_st = GOAL; i_start = 1'b1; end
            @(negedge clk);
            i_step_done = 1'b0; i_start = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            i_step_done = 1'b1; i_next_st = nxq[idx]; i_abort = (idx == abort_req);
            @(negedge clk);
            i_step_done = 1'b0; i_abort = 1'b0;
        end
        if (aborted) begin
            check("abort_busy", o_busy, 0);
            check("abort_goal_hits", o_goal_hits, ab.goals);
            check("abort_cur_st", o_cur_st, ab.st);
            check("abort_count", o_count, ab.ep);
            check("abort_step", o_step, ab.s);
            repeat (6) @(negedge clk);
        end else begin
            cnt = 0;
            while (!o_valid && cnt < 64) begin @(negedge clk); cnt++; end
            check("valid_wait", o_valid, 1);
            @(negedge clk);
            check("busy_after_done", o_busy, 0);
        end
        check("req_pulses", n_req_seen, exp_req);
        check("ep_end_pulses", n_ep_seen, exp_ep);
        check("valid_pulses", n_done_seen, aborted ? 0 : 1);
        check("queues_drained", req_q.size() + ep_q.size() + done_q.size(), 0);
        req_q.delete(); ep_q.delete(); done_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_step_done = 1'b0;
        i_first_st = 4'd0; i_next_st = 4'd0; mon_en = 1'b1;
        #2 check_all_zero("reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle_cycles("idle_no_start", 20);

        mon_en = 1'b0;
        i_first_st = 4'd9;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_mid_run", o_busy, 1);
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_reset_mid_run");
        @(negedge clk); rst_n = 1'b1;
        check_idle_cycles("idle_after_reset", 20);
        mon_en = 1'b1;

        do_run(4'd2, 0, -1, -1, -1);
        do_run(4'd5, 0, 1, 1, -1);
        do_run(4'd7, 100, -1, -1, 1);
        do_run(4'd1, 0, -1, -1, -1);
        do_run(4'd3, 0, 2, 3, -1);
        for (int i = 0; i < 10; i++)
            do_run(4'($urandom_range(0, 14)), 20, -1, -1, (i == 4) ? int'($urandom_range(0, 6)) : -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
